// File: rtl/serial_mmu_bridge.sv
// -----------------------------------------------------------------------------
// serial_mmu_bridge
//
// Bridges the MMU data port to the serial controller. Each MMU access that
// falls into the serial address window becomes at most one serial-controller
// transaction. Data writes are held off while the transmitter is busy, a
// ce-low gap is guaranteed between serial transactions, and a local CTRL word
// holds the RX-interrupt enable and the error-clear strobe.
//
// Window layout (word offsets from BASE_ADDR):
//   0 : serial data      (forwarded, se_addr_o = 0)
//   1 : serial status    (forwarded, se_addr_o = 1)
//   2 : local CTRL       bit0 = RX interrupt enable, bit31 write-1 clears err
//   3 .. WIN_WORDS-1 : reserved, reads 0, writes ignored, no error
//   >= WIN_WORDS or misaligned : unmapped, reads 0, sets sticky err
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   mem_*_i / mem_*_o  MMU request (ce held until mem_ready_o) and response
//   int_o              registered RX interrupt level (rx available & enable)
//   err_o              sticky error flag
//   se_*_o / se_*_i    serial controller request and response
//
// Optional feature macro: SERIAL_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent in ISSUE and WAIT_TX and
//   completes the access with 32'hFFFFFFFF and err set once it reaches
//   TIMEOUT. When undefined those states wait indefinitely.
// -----------------------------------------------------------------------------
module serial_mmu_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'hBFD003F8,
  parameter int unsigned WIN_WORDS = 32'd4
`ifdef SERIAL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 32'd1023
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        int_o,
  output logic        err_o,
  output logic        se_ce_o,
  output logic        se_we_o,
  output logic [2:0]  se_addr_o,
  output logic [31:0] se_data_o,
  output logic [3:0]  se_sel_o,
  input  logic [31:0] se_data_i,
  input  logic        se_ready_i,
  input  logic        se_read_enable_i,
  input  logic        se_write_busy_i
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_TX = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_DONE    = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        lat_we_q, lat_we_d;
  logic [2:0]  lat_addr_q, lat_addr_d;
  logic [31:0] lat_data_q, lat_data_d;
  logic [3:0]  lat_sel_q, lat_sel_d;
  logic        ien_q, ien_d;
  logic        err_q, err_d;
  logic        int_q, int_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        mem_ready_q, mem_ready_d;
  logic        se_ce_q, se_ce_d;
  logic        se_we_q, se_we_d;
  logic [2:0]  se_addr_q, se_addr_d;
  logic [31:0] se_data_q, se_data_d;
  logic [3:0]  se_sel_q, se_sel_d;
  logic        timeout_s;

  // Address decode. BASE_ADDR is word aligned, so the low bits of the
  // difference expose misalignment; addresses below the base wrap to a huge
  // offset and land in the unmapped range.
  logic [31:0] diff_s;
  logic [31:0] off_s;
  logic        unmapped_s;
  logic        is_data_s;
  logic        is_stat_s;
  logic        is_ctrl_s;

  assign diff_s     = mem_addr_i - BASE_ADDR;
  assign off_s      = {2'b00, diff_s[31:2]};
  assign unmapped_s = (diff_s[1:0] != 2'b00) || (off_s >= WIN_WORDS);
  assign is_data_s  = !unmapped_s && (off_s == 32'd0);
  assign is_stat_s  = !unmapped_s && (off_s == 32'd1);
  assign is_ctrl_s  = !unmapped_s && (off_s == 32'd2);

`ifdef SERIAL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT + 32'd1) : 32'd1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout_s = (cnt_q == CNT_W'(TIMEOUT));

  // Watchdog next value: restarts on every state change, counts only while
  // waiting on the transmitter or on the serial controller.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == ST_ISSUE) || (state_q == ST_WAIT_TX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Transaction FSM next state, request latch, local registers and the
  // next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    lat_we_d   = lat_we_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    lat_sel_d  = lat_sel_q;
    ien_d      = ien_q;
    err_d      = err_q;
    mem_data_d = mem_data_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_ce_i) begin
          lat_we_d   = mem_we_i;
          lat_addr_d = off_s[2:0];
          lat_data_d = mem_data_i;
          lat_sel_d  = mem_sel_i;
          if (unmapped_s) begin
            mem_data_d = 32'd0;
            err_d      = 1'b1;
            state_d    = ST_DONE;
          end else if (is_data_s || is_stat_s) begin
            // Only data writes feed the transmitter; status traffic and
            // reads go straight out.
            if (mem_we_i && is_data_s && se_write_busy_i) begin
              state_d = ST_WAIT_TX;
            end else begin
              state_d = ST_ISSUE;
            end
          end else if (is_ctrl_s) begin
            if (mem_we_i) begin
              mem_data_d = 32'd0;
              if (mem_sel_i[0]) begin
                ien_d = mem_data_i[0];
              end else begin
                ien_d = ien_q;
              end
              if (mem_data_i[31]) begin
                err_d = 1'b0;
              end else begin
                err_d = err_q;
              end
            end else begin
              mem_data_d = {31'd0, ien_q};
            end
            state_d = ST_DONE;
          end else begin
            // Reserved word inside the window: harmless, no error.
            mem_data_d = 32'd0;
            state_d    = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_TX: begin
        // A withdrawn request is abandoned before anything reaches the
        // serial controller.
        if (!mem_ce_i) begin
          state_d = ST_IDLE;
        end else if (timeout_s) begin
          mem_data_d = 32'hFFFF_FFFF;
          err_d      = 1'b1;
          state_d    = ST_DONE;
        end else if (!se_write_busy_i) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_WAIT_TX;
        end
      end

      ST_ISSUE: begin
        // Once issued the transaction always runs to completion, whatever
        // mem_ce_i does.
        if (se_ready_i) begin
          if (lat_we_q) begin
            mem_data_d = 32'd0;
          end else begin
            mem_data_d = se_data_i;
          end
          state_d = ST_DONE;
        end else if (timeout_s) begin
          mem_data_d = 32'hFFFF_FFFF;
          err_d      = 1'b1;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_DONE: begin
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        // Waiting for the MMU to drop ce keeps the access from being issued
        // twice and leaves se_ce_o low for at least DONE plus this cycle.
        if (mem_ce_i) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_ready_d = (state_d == ST_DONE);
    se_ce_d     = (state_d == ST_ISSUE);
    if (se_ce_d) begin
      se_we_d   = lat_we_d;
      se_addr_d = lat_addr_d;
      se_data_d = lat_data_d;
      se_sel_d  = lat_sel_d;
    end else begin
      se_we_d   = 1'b0;
      se_addr_d = 3'd0;
      se_data_d = 32'd0;
      se_sel_d  = 4'd0;
    end

    // Uses the enable being written this cycle, so a CTRL write and a
    // rising RX flag in the same cycle resolve to the new enable.
    int_d = se_read_enable_i & ien_d;
  end

  // State, latch, local registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= 3'd0;
      lat_data_q  <= 32'd0;
      lat_sel_q   <= 4'd0;
      ien_q       <= 1'b0;
      err_q       <= 1'b0;
      int_q       <= 1'b0;
      mem_data_q  <= 32'd0;
      mem_ready_q <= 1'b0;
      se_ce_q     <= 1'b0;
      se_we_q     <= 1'b0;
      se_addr_q   <= 3'd0;
      se_data_q   <= 32'd0;
      se_sel_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_data_q  <= lat_data_d;
      lat_sel_q   <= lat_sel_d;
      ien_q       <= ien_d;
      err_q       <= err_d;
      int_q       <= int_d;
      mem_data_q  <= mem_data_d;
      mem_ready_q <= mem_ready_d;
      se_ce_q     <= se_ce_d;
      se_we_q     <= se_we_d;
      se_addr_q   <= se_addr_d;
      se_data_q   <= se_data_d;
      se_sel_q    <= se_sel_d;
    end
  end

  assign mem_data_o  = mem_data_q;
  assign mem_ready_o = mem_ready_q;
  assign int_o       = int_q;
  assign err_o       = err_q;
  assign se_ce_o     = se_ce_q;
  assign se_we_o     = se_we_q;
  assign se_addr_o   = se_addr_q;
  assign se_data_o   = se_data_q;
  assign se_sel_o    = se_sel_q;

endmodule

// File: tb/tb_serial_mmu_bridge.sv
// -----------------------------------------------------------------------------
// tb_serial_mmu_bridge
//
// Acts as the MMU and as the serial controller. Expected results come from a
// transaction-level model: address class from window arithmetic, latency as
// 1 + transmitter stall + controller wait, read data from the class, and the
// ien/err/int values from the CTRL rules.
// -----------------------------------------------------------------------------
module tb_serial_mmu_bridge;

  localparam logic [31:0] BASE = 32'hBFD003F8;

  logic        clk;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_o;
  logic        mem_ready_o;
  logic        int_o;
  logic        err_o;
  logic        se_ce_o;
  logic        se_we_o;
  logic [2:0]  se_addr_o;
  logic [31:0] se_data_o;
  logic [3:0]  se_sel_o;
  logic [31:0] se_data_i;
  logic        se_ready_i;
  logic        se_read_enable_i;
  logic        se_write_busy_i;

  int   passed = 0;
  int   total = 0;
  int   ce_pulses = 0;
  int   ready_cycles = 0;
  int   exp_ce = 0;
  int   exp_ready = 0;
  logic ce_prev = 1'b0;
  logic ien_m = 1'b0;
  logic err_m = 1'b0;

  serial_mmu_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .mem_ce_i         (mem_ce_i),
    .mem_we_i         (mem_we_i),
    .mem_addr_i       (mem_addr_i),
    .mem_data_i       (mem_data_i),
    .mem_sel_i        (mem_sel_i),
    .mem_data_o       (mem_data_o),
    .mem_ready_o      (mem_ready_o),
    .int_o            (int_o),
    .err_o            (err_o),
    .se_ce_o          (se_ce_o),
    .se_we_o          (se_we_o),
    .se_addr_o        (se_addr_o),
    .se_data_o        (se_data_o),
    .se_sel_o         (se_sel_o),
    .se_data_i        (se_data_i),
    .se_ready_i       (se_ready_i),
    .se_read_enable_i (se_read_enable_i),
    .se_write_busy_i  (se_write_busy_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Counts serial-request pulses and completion cycles over the whole run.
  always @(negedge clk) begin
    if (se_ce_o && !ce_prev) ce_pulses++;
    if (mem_ready_o) ready_cycles++;
    ce_prev = se_ce_o;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // 0 data, 1 status, 2 ctrl, 3 reserved, 9 unmapped
  function automatic int classify(input logic [31:0] addr);
    logic [31:0] d;
    d = addr - BASE;
    if ((d % 32'd4) != 32'd0) return 9;
    if ((d / 32'd4) >= 32'd4) return 9;
    return int'(d / 32'd4);
  endfunction

  // One MMU access. Entered and left just after a falling edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input int busy_n, input int rdy_n,
                        input logic rx, input logic [31:0] ctl_data, input int extra);
    int          kind;
    int          stall;
    int          lat_exp;
    int          lat;
    int          ce_cnt;
    int          first_ce;
    logic        serial;
    logic        got;
    logic        ien_before;
    logic [31:0] exp_data;
    logic [31:0] rdata;

    kind       = classify(addr);
    serial     = (kind == 0) || (kind == 1);
    stall      = (serial && we && kind == 0) ? busy_n : 0;
    lat_exp    = serial ? (1 + stall + rdy_n) : 1;
    ien_before = ien_m;
    if (kind == 2 && we) begin
      if (sel[0]) ien_m = wdata[0];
      if (wdata[31]) err_m = 1'b0;
    end
    if (kind == 9) err_m = 1'b1;
    if (we) exp_data = 32'd0;
    else if (serial) exp_data = ctl_data;
    else if (kind == 2) exp_data = {31'd0, ien_before};
    else exp_data = 32'd0;

    mem_ce_i         = 1'b1;
    mem_we_i         = we;
    mem_addr_i       = addr;
    mem_data_i       = wdata;
    mem_sel_i        = sel;
    se_read_enable_i = rx;
    se_write_busy_i  = (busy_n > 0);
    se_data_i        = ctl_data;
    se_ready_i       = 1'b0;
    got = 1'b0; lat = 0; ce_cnt = 0; first_ce = 0; rdata = 32'd0;

    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (k == 1) chk("int_err_at_acc_plus_1", {78'd0, int_o, err_o}, {78'd0, rx & ien_m, err_m});
      if (mem_ready_o) begin
        got   = 1'b1;
        lat   = k;
        rdata = mem_data_o;
        chk("se_ce_low_in_done", {79'd0, se_ce_o}, 80'd0);
      end else begin
        if (se_ce_o) begin
          ce_cnt++;
          if (ce_cnt == 1) begin
            first_ce = k;
            chk("se_fields", {40'd0, se_we_o, se_addr_o, se_sel_o, se_data_o},
                {40'd0, we, 3'(kind), sel, wdata});
          end
        end
        se_write_busy_i = (k < busy_n);
        se_ready_i      = se_ce_o && (ce_cnt == rdy_n);
      end
    end
    se_ready_i      = 1'b0;
    se_write_busy_i = 1'b0;

    chk("ready_seen", {79'd0, got}, 80'd1);
    chk("latency", 80'(lat), 80'(lat_exp));
    chk("read_data", {48'd0, rdata}, {48'd0, exp_data});
    chk("se_ce_cycles", 80'(ce_cnt), 80'(serial ? rdy_n : 0));
    chk("first_se_ce", 80'(first_ce), 80'(serial ? (1 + stall) : 0));
    exp_ready++;
    if (serial) exp_ce++;

    repeat (extra) begin
      @(negedge clk);
      chk("hold_no_reissue", {78'd0, mem_ready_o, se_ce_o}, 80'd0);
    end
    @(negedge clk);
    mem_ce_i = 1'b0;
    chk("hold_quiet", {78'd0, mem_ready_o, se_ce_o}, 80'd0);
    @(negedge clk);
    chk("idle_state", {76'd0, mem_ready_o, se_ce_o, int_o, err_o},
        {76'd0, 1'b0, 1'b0, rx & ien_m, err_m});
  endtask

  initial begin
    int          c;
    logic        rnd_we;
    logic        rnd_rx;
    logic [31:0] rnd_addr;

    rst = 1'b0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'd0; mem_data_i = 32'd0;
    mem_sel_i = 4'd0; se_data_i = 32'd0; se_ready_i = 1'b0;
    se_read_enable_i = 1'b0; se_write_busy_i = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", {4'd0, mem_data_o, mem_ready_o, int_o, err_o, se_ce_o, se_we_o,
                          se_addr_o, se_data_o, se_sel_o}, 80'd0);
    rst = 1'b1;
    @(negedge clk);

    // Status read returning both status bits.
    access(1'b0, BASE + 32'd4, 32'd0, 4'hF, 0, 2, 1'b1, 32'h0000_0003, 0);
    // Data write stalled by a 20-cycle busy transmitter.
    access(1'b1, BASE, 32'h0000_0041, 4'h1, 20, 1, 1'b0, 32'hDEAD_BEEF, 0);
    // Back-to-back data reads with a single ce-low cycle between them.
    access(1'b0, BASE, 32'd0, 4'hF, 0, 1, 1'b0, 32'h0000_0055, 0);
    access(1'b0, BASE, 32'd0, 4'hF, 0, 3, 1'b0, 32'h0000_00AA, 0);
    // Enable RX interrupt while RX flag rises in the same cycle, then disable.
    access(1'b1, BASE + 32'd8, 32'h0000_0001, 4'h1, 0, 1, 1'b1, 32'd0, 0);
    access(1'b0, BASE + 32'd8, 32'd0, 4'hF, 0, 1, 1'b1, 32'd0, 0);
    access(1'b1, BASE + 32'd8, 32'h0000_0000, 4'h1, 0, 1, 1'b1, 32'd0, 0);
    access(1'b0, BASE + 32'd8, 32'd0, 4'hF, 0, 1, 1'b1, 32'd0, 0);
    // Unmapped read sets err; CTRL bit31 clears it.
    access(1'b0, 32'hBFD0_0410, 32'd0, 4'hF, 0, 1, 1'b0, 32'h1234_5678, 0);
    access(1'b1, BASE + 32'd8, 32'h8000_0000, 4'hF, 0, 1, 1'b0, 32'd0, 0);
    // ce held high after completion must not re-issue.
    access(1'b0, BASE, 32'd0, 4'hF, 0, 2, 1'b0, 32'hCAFE_F00D, 3);
    // Misaligned write, then err clear with lane 0 disabled (ien untouched).
    access(1'b1, BASE + 32'd1, 32'h0000_0077, 4'hF, 0, 1, 1'b0, 32'd0, 0);
    access(1'b1, BASE + 32'd8, 32'h8000_0001, 4'hE, 0, 1, 1'b0, 32'd0, 0);

    for (int i = 0; i < 40; i++) begin
      c      = int'($urandom_range(0, 5));
      rnd_we = 1'($urandom_range(0, 1));
      rnd_rx = 1'($urandom_range(0, 1));
      case (c)
        0: access(1'b0, BASE, $urandom, 4'hF, int'($urandom_range(0, 4)),
                  int'($urandom_range(1, 4)), rnd_rx, $urandom, 0);
        1: access(1'b1, BASE, $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 6)),
                  int'($urandom_range(1, 4)), rnd_rx, $urandom, int'($urandom_range(0, 2)));
        2: access(rnd_we, BASE + 32'd4, $urandom, 4'($urandom_range(1, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), rnd_rx, $urandom, 0);
        3: access(rnd_we, BASE + 32'd8, $urandom, 4'($urandom_range(0, 15)), 0, 1,
                  rnd_rx, $urandom, 0);
        4: begin
          rnd_addr = BASE + 32'd4 * 32'($urandom_range(4, 300));
          access(rnd_we, rnd_addr, $urandom, 4'hF, 0, 1, rnd_rx, $urandom, 0);
        end
        default: begin
          rnd_addr = BASE + 32'd4 * 32'($urandom_range(0, 2)) + 32'($urandom_range(1, 3));
          access(rnd_we, rnd_addr, $urandom, 4'hF, 0, 1, rnd_rx, $urandom, 0);
        end
      endcase
    end

    // Asynchronous reset while a read is stuck in ISSUE.
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = BASE; mem_sel_i = 4'hF;
    se_ready_i = 1'b0; se_read_enable_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("se_ce_before_reset", {79'd0, se_ce_o}, 80'd1);
    #2 rst = 1'b0;
    #1 chk("async_reset_outputs", {4'd0, mem_data_o, mem_ready_o, int_o, err_o, se_ce_o,
                                   se_we_o, se_addr_o, se_data_o, se_sel_o}, 80'd0);
    exp_ce++;
    mem_ce_i = 1'b0;
    ien_m = 1'b0;
    err_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, BASE + 32'd8, 32'd0, 4'hF, 0, 1, 1'b1, 32'd0, 0);

    chk("se_ce_pulse_count", 80'(ce_pulses), 80'(exp_ce));
    chk("mem_ready_cycle_count", 80'(ready_cycles), 80'(exp_ready));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
